// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory/MMIO bus between the CPU fetch
// port (I) and the load/store port (D). Each winning request is registered,
// issued to the slave, and completed either by the slave's acknowledge or
// by a timeout. A one-cycle acknowledge with read data then goes back to
// the master that was granted.
module bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,

  // Instruction-fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [XLEN-1:0]     i_rdata,
  output logic                i_ack,
  output logic                i_err,

  // Load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [XLEN/8-1:0]   d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  output logic [XLEN-1:0]     d_rdata,
  output logic                d_ack,
  output logic                d_err,

  // Slave (address decoder) side
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack
);

  localparam int STRB_W = XLEN / 8;
  localparam int CNT_W  = $clog2(TIMEOUT);

  // Last cycle of ISSUE before the transaction is declared timed out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Master identifiers held in last_grant.
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]        state, state_d;
  logic              last_grant, last_grant_d;   // also the current owner
  logic [CNT_W-1:0]  cnt, cnt_d;

  // Latched request and response
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  // Strobes from the controller to the datapath
  logic              take_req;    // capture the winner's request this edge
  logic              take_ack;    // slave answered: capture mem_rdata
  logic              take_tmo;    // timed out: capture error response

  // ---------------------------------------------------------------------
  // Next-state and arbitration decision
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    take_req     = 1'b0;
    take_ack     = 1'b0;
    take_tmo     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            // Contention: the master that did not win last time goes next.
            last_grant_d = ~last_grant;
          end else if (d_req) begin
            last_grant_d = SEL_D;
          end else begin
            last_grant_d = SEL_I;
          end
          take_req = 1'b1;
          cnt_d    = '0;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_ack) begin
          take_ack = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          take_tmo = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        // Requests are deliberately not sampled here; the master gets one
        // cycle to drop req after its ack.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control registers: state, round-robin pointer, timeout counter
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= SEL_D;     // makes I win the first contest after reset
      cnt        <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Request capture: the granted master's command, frozen through ISSUE
  // ---------------------------------------------------------------------
  // NOTE: these data registers are reset too, because they drive module
  // outputs directly and the bus must read all-zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
    end else if (take_req) begin
      if (last_grant_d == SEL_I) begin
        // Fetches are always reads.
        addr_q  <= i_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
        wstrb_q <= '0;
      end else begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        we_q    <= d_we;
        wstrb_q <= d_wstrb;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response capture: slave data on ack, zero data plus error on timeout
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (take_ack) begin
      rdata_q <= mem_rdata;
      err_q   <= 1'b0;
    end else if (take_tmo) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic resp_i;
  logic resp_d;

  assign resp_i = (state == ST_RESP) && (last_grant == SEL_I);
  assign resp_d = (state == ST_RESP) && (last_grant == SEL_D);

  assign mem_req   = (state == ST_ISSUE);
  assign mem_we    = we_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Read data is gated so the idle port never sees the other's data.
  assign i_ack   = resp_i;
  assign i_err   = resp_i & err_q;
  assign i_rdata = resp_i ? rdata_q : '0;

  assign d_ack   = resp_d;
  assign d_err   = resp_d & err_q;
  assign d_rdata = resp_d ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_bus_arbiter;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [XLEN-1:0]   i_rdata;
  logic              i_ack;
  logic              i_err;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN-1:0]   d_rdata;
  logic              d_ack;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wstrb   (d_wstrb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_req;
    logic [31:0] exp_addr;
    logic        exp_i;

    reset     = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_wstrb   = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_i_ack",   i_ack,   0);
    check("rst_d_ack",   d_ack,   0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we",  mem_we,  0);
    reset = 1'b0;
    tick();

    // ---------------- Single fetch ----------------
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    tick();                                   // ISSUE
    check("fetch_mem_req",   mem_req,   1);
    check("fetch_mem_addr",  mem_addr,  32'h100);
    check("fetch_mem_we",    mem_we,    0);
    check("fetch_mem_wstrb", mem_wstrb, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    tick();                                   // RESP
    mem_ack = 1'b0;
    check("fetch_i_ack",   i_ack,   1);
    check("fetch_i_rdata", i_rdata, 32'h13);
    check("fetch_i_err",   i_err,   0);
    check("fetch_d_ack",   d_ack,   0);
    check("fetch_d_rdata", d_rdata, 0);
    check("fetch_req_drop", mem_req, 0);
    i_req = 1'b0;
    tick();                                   // IDLE
    check("fetch_ack_once", i_ack, 0);
    check("fetch_idle_req", mem_req, 0);

    // ---------------- Store ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_wstrb = 4'b0011;
    d_addr  = 32'h8000_0000;
    d_wdata = 32'h0000_CAFE;
    tick();
    check("st_mem_req",   mem_req,   1);
    check("st_mem_we",    mem_we,    1);
    check("st_mem_wstrb", mem_wstrb, 4'b0011);
    check("st_mem_addr",  mem_addr,  32'h8000_0000);
    check("st_mem_wdata", mem_wdata, 32'h0000_CAFE);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0;
    check("st_d_ack", d_ack, 1);
    check("st_d_err", d_err, 0);
    check("st_i_ack", i_ack, 0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check("st_ack_once", d_ack, 0);

    // ---------------- Contention from reset ----------------
    reset = 1'b1;
    tick();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_wstrb = 4'b0000;
    d_addr  = 32'h0000_0300;
    reset   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_i    = (k % 2 == 0);                // I, D, I, D
      exp_addr = exp_i ? 32'h200 : 32'h300;
      tick();                                 // ISSUE
      check($sformatf("rr%0d_mem_req", k),  mem_req,  1);
      check($sformatf("rr%0d_mem_addr", k), mem_addr, exp_addr);
      mem_ack   = 1'b1;
      mem_rdata = 32'hA000_0000 + 32'(k);
      tick();                                 // RESP
      mem_ack = 1'b0;
      check($sformatf("rr%0d_i_ack", k),   i_ack,   exp_i ? 1 : 0);
      check($sformatf("rr%0d_d_ack", k),   d_ack,   exp_i ? 0 : 1);
      check($sformatf("rr%0d_i_rdata", k), i_rdata, exp_i ? 32'hA000_0000 + 32'(k) : 32'h0);
      check($sformatf("rr%0d_d_rdata", k), d_rdata, exp_i ? 32'h0 : 32'hA000_0000 + 32'(k));
      if (k == 3) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      tick();                                 // IDLE
    end
    check("rr_idle_req", mem_req, 0);

    // ---------------- Timeout ----------------
    d_req     = 1'b1;
    d_addr    = 32'h0000_0400;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    n_req = 0;
    for (int c = 0; c < 40 && mem_req; c++) begin
      n_req++;
      check("tmo_no_ack_yet", d_ack, 0);
      tick();
    end
    check("tmo_req_cycles", n_req, TIMEOUT);
    check("tmo_d_ack",   d_ack,   1);
    check("tmo_d_err",   d_err,   1);
    check("tmo_d_rdata", d_rdata, 0);
    check("tmo_i_ack",   i_ack,   0);
    d_req = 1'b0;
    tick();
    tick();
    tick();
    mem_ack = 1'b1;                           // late ack, must be ignored
    tick();
    mem_ack = 1'b0;
    check("late_ack_d", d_ack, 0);
    check("late_ack_i", i_ack, 0);
    check("late_ack_req", mem_req, 0);
    tick();
    check("late_ack_d2", d_ack, 0);
    d_req  = 1'b1;
    d_addr = 32'h0000_0500;
    tick();
    check("post_tmo_addr", mem_addr, 32'h500);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    tick();
    mem_ack = 1'b0;
    check("post_tmo_ack",   d_ack,   1);
    check("post_tmo_rdata", d_rdata, 32'h55);
    check("post_tmo_err",   d_err,   0);
    d_req = 1'b0;
    tick();

    // ---------------- Reset mid-transaction ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_wstrb = 4'b1111;
    d_addr  = 32'h0000_0580;
    tick();                                   // ISSUE for D
    check("mid_issue", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_req",   mem_req, 0);
    check("mid_rst_i_ack", i_ack,   0);
    check("mid_rst_d_ack", d_ack,   0);
    i_req  = 1'b1;
    i_addr = 32'h0000_0600;
    tick();
    check("mid_rst_no_ack", d_ack, 0);
    reset = 1'b0;
    tick();                                   // I wins after reset
    check("mid_grant_addr", mem_addr, 32'h600);
    check("mid_grant_we",   mem_we,   0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0;
    check("mid_i_ack",   i_ack,   1);
    check("mid_i_rdata", i_rdata, 32'h77);
    check("mid_d_ack",   d_ack,   0);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // ---------------- Slow slave ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_wstrb = 4'b1111;
    d_addr  = 32'h0000_0700;
    d_wdata = 32'h1234_5678;
    tick();
    d_addr  = 32'hDEAD_0000;                  // must not reach the bus
    d_wdata = 32'hBAD0_BAD0;
    d_we    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("slow%0d_req", c),   mem_req,   1);
      check($sformatf("slow%0d_addr", c),  mem_addr,  32'h700);
      check($sformatf("slow%0d_wdata", c), mem_wdata, 32'h1234_5678);
      check($sformatf("slow%0d_we", c),    mem_we,    1);
      check($sformatf("slow%0d_ack", c),   d_ack,     0);
      tick();
    end
    check("slow_req_held", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("slow_d_ack",   d_ack,   1);
    check("slow_req_off", mem_req, 0);
    d_req = 1'b0;
    tick();
    check("slow_ack_once", d_ack,   0);
    check("slow_no_reissue", mem_req, 0);
    tick();
    check("slow_no_reissue2", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
